// File: rtl/frag_tlp_buffer.sv
// rtl/frag_tlp_buffer.sv - circular fragmentation buffer: 1..MAX_WR_LOCS locations per write, one per read
// Optional macro FRAG_BUF_FWFT_EN selects a first-word fall-through read port.
module frag_tlp_buffer #(
    parameter int LOC_WIDTH       = 32,
    parameter int MAX_WR_LOCS     = 8,
    parameter int DEPTH           = 64,
    parameter int NO_LOC_WR_WIDTH = $clog2(MAX_WR_LOCS + 1),
    parameter int CNT_WIDTH       = $clog2(DEPTH + 1),
    parameter int WR_DATA_WIDTH   = LOC_WIDTH * MAX_WR_LOCS
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       wr_en,
    input  logic [WR_DATA_WIDTH-1:0]   data_in,
    input  logic [NO_LOC_WR_WIDTH-1:0] no_loc_wr,
    output logic                       empty,
    output logic                       full,
    output logic [CNT_WIDTH-1:0]       free_locs,
    input  logic                       rd_en,
    output logic [LOC_WIDTH-1:0]       data_out,
    output logic                       rd_valid,
    output logic                       wr_err
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] MAX_C   = CNT_WIDTH'(MAX_WR_LOCS);

    logic [LOC_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_next;
    logic [CNT_WIDTH-1:0] locs_ext;
    logic                 accept;
    logic                 drop;
    logic                 pop;

    // Space is judged on the registered free_locs; a same-cycle pop does not make room.
    always_comb begin
        locs_ext = CNT_WIDTH'(no_loc_wr);
        accept   = 1'b0;
        drop     = 1'b0;
        if (wr_en && no_loc_wr != '0) begin
            if (locs_ext <= MAX_C && locs_ext <= free_locs) begin
                accept = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        pop        = rd_en && !empty;
        count_next = count + (accept ? locs_ext : '0) - (pop ? CNT_WIDTH'(1) : '0);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            free_locs <= DEPTH_C;
            wr_err    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(no_loc_wr);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            count     <= count_next;
            empty     <= (count_next == '0);
            free_locs <= DEPTH_C - count_next;
            full      <= ((DEPTH_C - count_next) < MAX_C);
            wr_err    <= drop;
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < MAX_WR_LOCS; k++) begin
                if (k < int'(no_loc_wr)) begin
                    mem[wr_ptr + PTR_WIDTH'(k)] <= data_in[k*LOC_WIDTH +: LOC_WIDTH];
                end
            end
        end
    end

`ifdef FRAG_BUF_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr];
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                data_out <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_frag_tlp_buffer.sv
// tb/tb_frag_tlp_buffer.sv - randomized scoreboard bench for frag_tlp_buffer
module tb_frag_tlp_buffer;
    localparam int LW = 32;
    localparam int ML = 8;
    localparam int DP = 64;

    logic         clk = 1'b0;
    logic         arst = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [255:0] data_in = '0;
    logic [3:0]   no_loc_wr = '0;
    logic         empty;
    logic         full;
    logic         rd_valid;
    logic         wr_err;
    logic [6:0]   free_locs;
    logic [31:0]  data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int total_wr = 0;
    logic [31:0] model_q[$];
    logic [31:0] exp_rd[$];

    always #5 clk = ~clk;

    frag_tlp_buffer dut (
        .clk       (clk),
        .arst      (arst),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .no_loc_wr (no_loc_wr),
        .empty     (empty),
        .full      (full),
        .free_locs (free_locs),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .wr_err    (wr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard whenever the DUT presents a read word.
    always @(negedge clk) begin
        if (arst) begin
`ifdef FRAG_BUF_FWFT_EN
            if (rd_valid && rd_en) begin
`else
            if (rd_valid) begin
`endif
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got read word %0h expected no read", data_out);
                end else begin
                    check("rd_data", data_out, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic rand_data();
        for (int k = 0; k < ML; k++) data_in[k*LW +: LW] = $urandom;
    endtask

    // One clock of stimulus; the reference model is a plain queue of stored words.
    task automatic cycle(input bit wr, input int n, input bit rd);
        int free;
        bit acc;
        bit drop;
        bit pop;
        free = DP - model_q.size();
        wr_en = wr;
        no_loc_wr = 4'(n);
        rd_en = rd;
        acc  = wr && n >= 1 && n <= ML && n <= free;
        drop = wr && n != 0 && !acc;
        pop  = rd && model_q.size() > 0;
        if (pop) exp_rd.push_back(model_q.pop_front());
        if (acc) begin
            for (int k = 0; k < n; k++) model_q.push_back(data_in[k*LW +: LW]);
            total_wr += n;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        no_loc_wr = '0;
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("free_locs", 32'(free_locs), 32'(DP - model_q.size()));
        check("full", 32'(full), 32'((DP - model_q.size()) < ML));
        check("wr_err", 32'(wr_err), 32'(drop));
    endtask

    task automatic drain();
        while (model_q.size() > 0) cycle(0, 0, 1);
        cycle(0, 0, 0);
    endtask

    initial begin
        int gap;
        int m;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_free", 32'(free_locs), 32'd64);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        arst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            rand_data();
            cycle(1, 8, 0);
        end
        drain();

        data_in = '0;
        for (int k = 0; k < 5; k++) data_in[k*LW +: LW] = 32'hA0 + 32'(k);
        cycle(1, 5, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 1);
        cycle(0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            rand_data();
            cycle(1, 8, 0);
        end
        rand_data();
        cycle(1, 4, 0);
        rand_data();
        cycle(1, 5, 0);
        rand_data();
        cycle(1, 4, 0);
        rand_data();
        cycle(1, 1, 1);
        drain();

        gap = (62 - (total_wr % DP) + DP) % DP;
        while (gap > 0) begin
            m = (gap > ML) ? ML : gap;
            rand_data();
            cycle(1, m, 0);
            gap -= m;
        end
        drain();
        data_in = '0;
        for (int k = 0; k < 4; k++) data_in[k*LW +: LW] = 32'(k + 1);
        cycle(1, 4, 0);
        drain();

        rand_data();
        cycle(1, 8, 0);
        rand_data();
        cycle(1, 2, 0);
        rand_data();
        cycle(1, 3, 1);
        cycle(1, 0, 0);
        cycle(1, 9, 0);
        cycle(1, 15, 0);
        drain();

        for (int i = 0; i < 400; i++) begin
            rand_data();
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 10), 1'($urandom_range(0, 1)));
        end
        drain();

        rand_data();
        cycle(1, 8, 0);
        rand_data();
        cycle(1, 8, 0);
        rand_data();
        cycle(1, 5, 0);
        cycle(0, 0, 1);
        arst = 1'b0;
        #1;
        model_q.delete();
        exp_rd.delete();
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_free", 32'(free_locs), 32'd64);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
        arst = 1'b1;
        cycle(0, 0, 1);
        check("rd_valid_empty", 32'(rd_valid), 32'd0);
        cycle(0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("pending_reads", 32'(exp_rd.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
